// File: rtl/cam_learn_ctrl_if.sv
// rtl/cam_learn_ctrl_if.sv - request/response handshake bundle for cam_learn_ctrl
interface cam_learn_ctrl_if #(
  parameter int KEY_W  = 48,
  parameter int ADDR_W = 7
);
  logic              req_valid;
  logic              req_ready;
  logic [KEY_W-1:0]  req_key;
  logic              req_learn;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_hit;
  logic              rsp_multi;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_learned;
  logic              rsp_evict;
  logic              rsp_err;

  // requester side: issues lookups, consumes responses
  modport master (
    output req_valid, req_key, req_learn, rsp_ready,
    input  req_ready, rsp_valid, rsp_hit, rsp_multi, rsp_addr, rsp_learned, rsp_evict, rsp_err
  );

  // controller side
  modport slave (
    input  req_valid, req_key, req_learn, rsp_ready,
    output req_ready, rsp_valid, rsp_hit, rsp_multi, rsp_addr, rsp_learned, rsp_evict, rsp_err
  );
endinterface

// File: rtl/cam_learn_ctrl.sv
// rtl/cam_learn_ctrl.sv - CAM lookup/learn sequencer with power-up sweep to the empty pattern
module cam_learn_ctrl #(
  parameter int               KEY_W     = 48,
  parameter int               ADDR_W    = 7,
  parameter int               NUM_WORDS = 128,
  parameter int               CAM_LAT   = 1,
  parameter logic [KEY_W-1:0] INIT_KEY  = {KEY_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  cam_learn_ctrl_if.slave   bus,
  output logic [KEY_W-1:0]  cam_data,
  output logic [ADDR_W-1:0] cam_wr_address,
  output logic              cam_we,
  output logic              cam_clock_en,
  output logic              cam_en_mask,
  output logic              cam_wr_mask,
  output logic              cam_wr_dc,
  input  logic [ADDR_W-1:0] cam_address,
  input  logic              cam_match,
  input  logic              cam_mul_match
);

  localparam int FILL_W = ADDR_W + 1;
  localparam int WAIT_W = (CAM_LAT > 1) ? $clog2(CAM_LAT) : 1;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_LOOK  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [ADDR_W-1:0]   init_cnt;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [FILL_W-1:0]   fill_cnt;
  logic [KEY_W-1:0]    key_r;
  logic                learn_r;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [KEY_W-1:0]    data_hold;
  logic                hit_r;
  logic                multi_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                learned_r;
  logic                evict_r;
  logic                err_r;

  assign cam_clock_en = ~rst;
  assign cam_en_mask  = 1'b0;
  assign cam_wr_mask  = 1'b0;
  assign cam_wr_dc    = 1'b0;

  assign bus.rsp_hit     = hit_r;
  assign bus.rsp_multi   = multi_r;
  assign bus.rsp_addr    = addr_r;
  assign bus.rsp_learned = learned_r;
  assign bus.rsp_evict   = evict_r;
  assign bus.rsp_err     = err_r;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_nx;
  end

  // next-state: sweep, then one lookup (plus optional learn) in flight at a time
  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:  if (init_cnt == ADDR_W'(NUM_WORDS - 1)) state_nx = S_IDLE;
      S_IDLE:  if (bus.req_valid) state_nx = (bus.req_key == INIT_KEY) ? S_RESP : S_LOOK;
      S_LOOK: begin
        if (wait_cnt == '0) begin
          if (cam_match)    state_nx = S_RESP;
          else if (learn_r) state_nx = S_WRITE;
          else              state_nx = S_RESP;
        end
      end
      S_WRITE: state_nx = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_INIT;
    endcase
  end

  // outputs: CAM port drive and handshake flags; everything reads 0 while reset is held
  always_comb begin
    bus.req_ready  = (state == S_IDLE);
    bus.rsp_valid  = (state == S_RESP);
    cam_we         = 1'b0;
    cam_data       = data_hold;
    cam_wr_address = init_cnt;
    case (state)
      S_INIT: begin
        cam_we   = 1'b1;
        cam_data = INIT_KEY;
      end
      S_LOOK: cam_data = key_r;
      S_WRITE: begin
        cam_we         = 1'b1;
        cam_data       = key_r;
        cam_wr_address = wr_ptr;
      end
      default: ;
    endcase
    if (rst) begin
      cam_we         = 1'b0;
      cam_data       = '0;
      cam_wr_address = '0;
    end
  end

  // datapath: sweep counter, request latch, CAM sampling, round-robin learn pointer, response flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt  <= '0;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      key_r     <= '0;
      learn_r   <= 1'b0;
      wait_cnt  <= '0;
      data_hold <= '0;
      hit_r     <= 1'b0;
      multi_r   <= 1'b0;
      addr_r    <= '0;
      learned_r <= 1'b0;
      evict_r   <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      data_hold <= cam_data;
      case (state)
        S_INIT: init_cnt <= init_cnt + 1'b1;
        S_IDLE: begin
          if (bus.req_valid) begin
            key_r    <= bus.req_key;
            learn_r  <= bus.req_learn;
            wait_cnt <= WAIT_W'(CAM_LAT - 1);
            if (bus.req_key == INIT_KEY) err_r <= 1'b1;
          end
        end
        S_LOOK: begin
          if (wait_cnt == '0) begin
            if (cam_match) begin
              hit_r   <= 1'b1;
              multi_r <= cam_mul_match;
              addr_r  <= cam_address;
            end else if (!learn_r) begin
              addr_r <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_WRITE: begin
          addr_r    <= wr_ptr;
          learned_r <= 1'b1;
          evict_r   <= (fill_cnt == FILL_W'(NUM_WORDS));
          wr_ptr    <= (wr_ptr == ADDR_W'(NUM_WORDS - 1)) ? '0 : wr_ptr + 1'b1;
          if (fill_cnt != FILL_W'(NUM_WORDS)) fill_cnt <= fill_cnt + 1'b1;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            hit_r     <= 1'b0;
            multi_r   <= 1'b0;
            addr_r    <= '0;
            learned_r <= 1'b0;
            evict_r   <= 1'b0;
            err_r     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_learn_ctrl.sv
// tb/tb_cam_learn_ctrl.sv - directed self-checking bench for cam_learn_ctrl with a behavioural CAM
module tb_cam_learn_ctrl;

  localparam logic [47:0] INIT_KEY = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] KEY_A    = 48'h0011_2233_4455;
  localparam logic [47:0] KEY_B    = 48'h0066_7788_99AA;
  localparam logic [47:0] BASE     = 48'h0000_1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] cam_data;
  logic [6:0]  cam_wr_address;
  logic        cam_we;
  logic        cam_clock_en;
  logic        cam_en_mask;
  logic        cam_wr_mask;
  logic        cam_wr_dc;
  logic [6:0]  cam_address;
  logic        cam_match;
  logic        cam_mul_match;

  cam_learn_ctrl_if #(.KEY_W(48), .ADDR_W(7)) bus ();

  cam_learn_ctrl #(.KEY_W(48), .ADDR_W(7), .NUM_WORDS(128), .CAM_LAT(1), .INIT_KEY(INIT_KEY)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .cam_data       (cam_data),
    .cam_wr_address (cam_wr_address),
    .cam_we         (cam_we),
    .cam_clock_en   (cam_clock_en),
    .cam_en_mask    (cam_en_mask),
    .cam_wr_mask    (cam_wr_mask),
    .cam_wr_dc      (cam_wr_dc),
    .cam_address    (cam_address),
    .cam_match      (cam_match),
    .cam_mul_match  (cam_mul_match)
  );

  always #5 clk = ~clk;

  // behavioural CAM: single-cycle lookup, lowest address wins
  logic [47:0] mem [0:127];
  logic        force_multi = 1'b0;
  int          wr_cnt = 0;
  logic [6:0]  wa_q [$];
  logic [47:0] wd_q [$];

  always @(posedge clk) begin
    if (cam_we && cam_clock_en) begin
      mem[cam_wr_address] <= cam_data;
      wr_cnt = wr_cnt + 1;
      wa_q.push_back(cam_wr_address);
      wd_q.push_back(cam_data);
    end
  end

  always_comb begin
    cam_match     = 1'b0;
    cam_mul_match = 1'b0;
    cam_address   = '0;
    for (int i = 127; i >= 0; i--) begin
      if (mem[i] == cam_data) begin
        if (cam_match) cam_mul_match = 1'b1;
        cam_match   = 1'b1;
        cam_address = i[6:0];
      end
    end
    if (force_multi) cam_mul_match = 1'b1;
  end

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  int          r_lat;
  int          r_nwr;
  logic        r_hit, r_multi, r_learned, r_evict, r_err, r_stable;
  logic [6:0]  r_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [47:0] key, input logic learn, input int hold);
    int w0;
    int n;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    w0 = wr_cnt;
    bus.req_valid = 1'b1;
    bus.req_key   = key;
    bus.req_learn = learn;
    @(negedge clk);
    bus.req_valid = 1'b0;
    r_lat = 1;
    while (!bus.rsp_valid && r_lat < 20) begin
      @(negedge clk);
      r_lat++;
    end
    r_hit = bus.rsp_hit; r_multi = bus.rsp_multi; r_addr = bus.rsp_addr;
    r_learned = bus.rsp_learned; r_evict = bus.rsp_evict; r_err = bus.rsp_err;
    r_stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.req_ready || bus.rsp_hit !== r_hit || bus.rsp_multi !== r_multi ||
          bus.rsp_addr !== r_addr || bus.rsp_learned !== r_learned || bus.rsp_evict !== r_evict ||
          bus.rsp_err !== r_err)
        r_stable = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    r_nwr = wr_cnt - w0;
  endtask

  int cyc;
  int bad;
  int w_save;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_key   = '0;
    bus.req_learn = 1'b0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = {16'hDEAD, 25'd0, i[6:0]};
    mem[3] = KEY_A;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_cam_we", cam_we, 0);
    chk("rst_cam_clock_en", cam_clock_en, 0);
    chk("rst_cam_data", cam_data, 0);

    // power-up sweep
    rst = 1'b0;
    cyc = 0;
    while (!bus.req_ready && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("sweep_cycles", cyc, 128);
    chk("sweep_writes", wa_q.size(), 128);
    bad = 0;
    for (int i = 0; i < wa_q.size(); i++) if (wa_q[i] != i[6:0] || wd_q[i] != INIT_KEY) bad++;
    chk("sweep_order", bad, 0);
    chk("clock_en_run", cam_clock_en, 1);
    chk("tied_masks", {cam_en_mask, cam_wr_mask, cam_wr_dc}, 0);

    // first learn: stale KEY_A at addr 3 was swept, so this misses and learns at 0
    do_req(KEY_A, 1'b1, 0);
    chk("learn_a_lat", r_lat, 3);
    chk("learn_a_flags", {r_hit, r_multi, r_learned, r_evict, r_err}, 5'b00100);
    chk("learn_a_addr", r_addr, 0);
    chk("learn_a_nwr", r_nwr, 1);
    chk("learn_a_wdata", wd_q[wd_q.size()-1], KEY_A);
    chk("learn_a_waddr", wa_q[wa_q.size()-1], 0);
    chk("idle_after_rsp", {bus.req_ready, bus.rsp_valid}, 2'b10);

    // same key hits without writing
    do_req(KEY_A, 1'b1, 0);
    chk("hit_a_lat", r_lat, 2);
    chk("hit_a_flags", {r_hit, r_multi, r_learned, r_evict, r_err}, 5'b10000);
    chk("hit_a_addr", r_addr, 0);
    chk("hit_a_nwr", r_nwr, 0);

    // unknown key without learn
    do_req(KEY_B, 1'b0, 0);
    chk("miss_b_lat", r_lat, 2);
    chk("miss_b_flags", {r_hit, r_multi, r_learned, r_evict, r_err}, 5'b00000);
    chk("miss_b_addr", r_addr, 0);
    chk("miss_b_nwr", r_nwr, 0);
    chk("cam_data_held", cam_data, KEY_B);

    // fill the rest of the table, then wrap and evict
    bad = 0;
    for (int i = 1; i <= 127; i++) begin
      do_req(BASE + 48'(i), 1'b1, 0);
      if (!r_learned || r_hit || r_evict || r_addr != i[6:0] || r_nwr != 1) bad++;
    end
    chk("fill_bad", bad, 0);
    do_req(BASE + 48'd128, 1'b1, 0);
    chk("wrap_addr", r_addr, 0);
    chk("wrap_evict", {r_learned, r_evict}, 2'b11);
    chk("wrap_waddr", wa_q[wa_q.size()-1], 0);
    do_req(BASE + 48'd129, 1'b1, 0);
    chk("wrap2_addr", r_addr, 1);
    chk("wrap2_evict", {r_learned, r_evict}, 2'b11);
    do_req(KEY_A, 1'b0, 0);
    chk("evicted_a_miss", r_hit, 0);

    // response held while consumer stalls
    do_req(BASE + 48'd5, 1'b0, 5);
    chk("hold_stable", r_stable, 1);
    chk("hold_hit", {r_hit, r_addr}, {1'b1, 7'd5});

    // multi-match reported as hit, never learned
    force_multi = 1'b1;
    do_req(BASE + 48'd7, 1'b1, 0);
    force_multi = 1'b0;
    chk("multi_flags", {r_hit, r_multi, r_learned, r_evict, r_err}, 5'b11000);
    chk("multi_addr", r_addr, 7);
    chk("multi_nwr", r_nwr, 0);

    // reserved key rejected
    do_req(INIT_KEY, 1'b1, 0);
    chk("err_lat", r_lat, 1);
    chk("err_flags", {r_hit, r_multi, r_learned, r_evict, r_err}, 5'b00001);
    chk("err_nwr", r_nwr, 0);

    // reset asserted while in WRITE
    bus.req_valid = 1'b1;
    bus.req_key   = 48'h0ABC_0000_0001;
    bus.req_learn = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("write_we", cam_we, 1);
    chk("write_addr", cam_wr_address, 2);
    rst = 1'b1;
    #1;
    chk("abort_outputs", {cam_we, bus.rsp_valid, bus.req_ready, cam_clock_en}, 4'b0000);
    chk("abort_data", cam_data, 0);
    w_save = wr_cnt;
    repeat (2) @(negedge clk);
    chk("abort_nwr", wr_cnt - w_save, 0);
    wa_q.delete();
    wd_q.delete();
    rst = 1'b0;
    cyc = 0;
    while (!bus.req_ready && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("resweep_cycles", cyc, 128);
    bad = 0;
    for (int i = 0; i < wa_q.size(); i++) if (wa_q[i] != i[6:0] || wd_q[i] != INIT_KEY) bad++;
    chk("resweep_order", {wa_q.size(), bad}, {32'd128, 32'd0});
    do_req(BASE + 48'd5, 1'b1, 0);
    chk("post_rst_learn", {r_hit, r_learned, r_evict, r_addr}, {3'b010, 7'd0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
